nibble_serial_subtractor: RTL and testbench

- Multi-cycle 16-bit subtractor computing in1 - in2 - borrow_in one 4-bit digit per clock, least-significant digit first, with a rippled borrow register.
- Arithmetic counterpart to the team's 16-bit ripple adder: the same digit-chained structure run in the subtract direction, time-multiplexed over a single 4-bit subtract cell.
- Sits in the ALU datapath behind a valid/ready handshake on both the operand side and the result side.

---
 rtl/nibble_serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = in1 - in2 - borrow_in, one DIGIT-wide
// digit per clock, LSB digit first, behind valid/ready handshakes on both sides.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int ND = WIDTH / DIGIT;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ND - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_out_q, borrow_out_d;
    logic               overflow_q, overflow_d;

    int                 dig_lsb_s;
    logic [DIGIT-1:0]   a_dig_s;
    logic [DIGIT-1:0]   b_dig_s;
    logic [DIGIT:0]     dig_s;

    // Single subtract cell: the top bit of the DIGIT+1 result is the outgoing borrow.
    always_comb begin
        dig_lsb_s = int'(cnt_q) * DIGIT;
        a_dig_s   = a_q[dig_lsb_s +: DIGIT];
        b_dig_s   = b_q[dig_lsb_s +: DIGIT];
        dig_s     = {1'b0, a_dig_s} - {1'b0, b_dig_s} - {{DIGIT{1'b0}}, borrow_q};
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        a_d          = a_q;
        b_d          = b_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    a_d          = in1;
                    b_d          = in2;
                    borrow_d     = borrow_in;
                    diff_d       = {WIDTH{1'b0}};
                    borrow_out_d = 1'b0;
                    overflow_d   = 1'b0;
                    cnt_d        = CNT_ZERO;
                    state_d      = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                diff_d[dig_lsb_s +: DIGIT] = dig_s[DIGIT-1:0];
                borrow_d                   = dig_s[DIGIT];
                if (cnt_q == CNT_LAST) begin
                    // diff_d already holds the final top digit here.
                    cnt_d        = CNT_ZERO;
                    borrow_out_d = dig_s[DIGIT];
                    overflow_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d      = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            borrow_q     <= 1'b0;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            diff_q       <= {WIDTH{1'b0}};
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            a_q          <= a_d;
            b_q          <= b_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_RUN);
    assign done_valid  = (state_q == ST_DONE);
    assign diff        = diff_q;
    assign borrow_out  = borrow_out_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed, table-driven bench for nibble_serial_subtractor plus handshake,
// backpressure and mid-operation reset sequences.
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        borrow_in;
    logic        busy;
    logic        done_valid;
    logic        done_ready;
    logic [15:0] diff;
    logic        borrow_out;
    logic        overflow;

    int checks;
    int errors;
    int cyc;
    int last_accept;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] exp_diff;
        logic        exp_bout;
        logic        exp_ov;
    } vec_t;

    vec_t vecs [10];

    nibble_serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .in1        (in1),
        .in2        (in2),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands at a negedge; returns after the acceptance edge has passed.
    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int n;
        n = 0;
        while (!start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready_before_accept", {31'd0, start_ready}, 32'd1);
        in1         = a;
        in2         = b;
        borrow_in   = bin;
        start_valid = 1'b1;
        @(negedge clk);
        last_accept = cyc;
        start_valid = 1'b0;
        in1         = 16'h5A5A;
        in2         = 16'hA5A5;
        borrow_in   = 1'b1;
    endtask

    // Count edges until done_valid; bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handback();
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        chk("idle_after_handback_start_ready", {31'd0, start_ready}, 32'd1);
        chk("idle_after_handback_done_valid", {31'd0, done_valid}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        accept(v.a, v.b, v.bin);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk("latency", lat, 32'd4);
        chk("diff", {16'd0, diff}, {16'd0, v.exp_diff});
        chk("borrow_out", {31'd0, borrow_out}, {31'd0, v.exp_bout});
        chk("overflow", {31'd0, overflow}, {31'd0, v.exp_ov});
        handback();
    endtask

    initial begin
        int lat;
        int t0;
        logic [15:0] held;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        last_accept = 0;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[6] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};

        rst_n       = 1'b0;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        in1         = 16'h0000;
        in2         = 16'h0000;
        borrow_in   = 1'b0;
        #12;
        chk("reset_start_ready", {31'd0, start_ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done_valid", {31'd0, done_valid}, 32'd0);
        chk("reset_diff", {16'd0, diff}, 32'd0);
        chk("reset_borrow_out", {31'd0, borrow_out}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure with ignored start_valid during RUN.
        accept(16'h1234, 16'h0234, 1'b0);
        start_valid = 1'b1;
        in1         = 16'h0000;
        in2         = 16'h0001;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        start_valid = 1'b1;
        wait_done(lat);
        start_valid = 1'b0;
        chk("bp_latency", lat, 32'd2);
        chk("bp_diff", {16'd0, diff}, 32'h1000);
        held = diff;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_done_valid_held", {31'd0, done_valid}, 32'd1);
            chk("bp_start_ready_low", {31'd0, start_ready}, 32'd0);
            chk("bp_diff_stable", {16'd0, diff}, {16'd0, held});
        end
        handback();
        chk("bp_diff_after_handback", {16'd0, diff}, 32'h1000);

        // Back-to-back operations: acceptances 6 cycles apart.
        accept(16'h0005, 16'h0003, 1'b0);
        t0 = last_accept;
        wait_done(lat);
        chk("b2b_first_latency", lat, 32'd4);
        handback();
        accept(16'h8000, 16'h0001, 1'b0);
        chk("b2b_spacing", last_accept - t0, 32'd6);
        wait_done(lat);
        chk("b2b_second_diff", {16'd0, diff}, 32'h7FFF);
        chk("b2b_second_overflow", {31'd0, overflow}, 32'd1);
        handback();

        // Reset while counter=2: two low digits written, then asynchronous clear.
        accept(16'hFFFF, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_partial_diff", {16'd0, diff}, 32'h00FF);
        rst_n = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_done_valid", {31'd0, done_valid}, 32'd0);
        chk("async_diff", {16'd0, diff}, 32'd0);
        chk("async_borrow_out", {31'd0, borrow_out}, 32'd0);
        chk("async_overflow", {31'd0, overflow}, 32'd0);
        chk("async_start_ready", {31'd0, start_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("reset_no_result", {31'd0, done_valid}, 32'd0);
        rst_n = 1'b1;
        accept(16'h0005, 16'h0003, 1'b0);
        wait_done(lat);
        chk("post_reset_latency", lat, 32'd4);
        chk("post_reset_diff", {16'd0, diff}, 32'h0002);
        chk("post_reset_borrow_out", {31'd0, borrow_out}, 32'd0);
        handback();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
